// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write arbiter: write entry layout and grant encoding.
package rf_arb_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_S0,
    GNT_S1
  } rf_gnt_e;

endpackage

// File: rtl/rf_wr_fifo.sv
// Small circular FIFO of pending register writes; exposes every live entry's address
// so the parent can answer hazard queries against buffered writes.
module rf_wr_fifo
  import rf_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push,
  input  rf_wr_t                           din,
  input  logic                             pop,
  output rf_wr_t                           head,
  output logic                             empty,
  output logic                             full,
  output logic [DEPTH-1:0]                 ent_valid,
  output logic [DEPTH-1:0][RF_ADDR_W-1:0]  ent_addr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  rf_wr_t         mem [DEPTH];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic [CW-1:0]  count;
  logic           do_push;
  logic           do_pop;
  logic [AW-1:0]  offset;

  // full is judged on the pre-pop count, so a full FIFO never accepts in its pop cycle
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wptr] <= din;
  end

  // a slot is live when its distance from the read pointer is below the occupancy
  always_comb begin
    offset    = '0;
    ent_valid = '0;
    ent_addr  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset       = AW'(i) - rptr;
      ent_valid[i] = ({1'b0, offset} < count);
      ent_addr[i]  = mem[i].addr;
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between ALU (s0) and load (s1) writeback FIFOs.
// Define RFARB_RR_EN for round-robin; otherwise s1 has priority with an s0 starvation bound.
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s0_valid,
  output logic                 s0_ready,
  input  logic [RF_ADDR_W-1:0] s0_addr,
  input  logic [RF_DATA_W-1:0] s0_data,
  input  logic                 s1_valid,
  output logic                 s1_ready,
  input  logic [RF_ADDR_W-1:0] s1_addr,
  input  logic [RF_DATA_W-1:0] s1_data,
  output logic                 RegWrite,
  output logic [RF_ADDR_W-1:0] a3,
  output logic [RF_DATA_W-1:0] wd3,
  input  logic [RF_ADDR_W-1:0] q_addr,
  output logic                 q_pending
);

  rf_wr_t                          s0_head, s1_head;
  logic                            s0_empty, s0_full, s1_empty, s1_full;
  logic [DEPTH-1:0]                s0_ev, s1_ev;
  logic [DEPTH-1:0][RF_ADDR_W-1:0] s0_ea, s1_ea;
  rf_gnt_e                         gnt;

  rf_wr_fifo #(.DEPTH(DEPTH)) u_fifo_s0 (
    .clk       (clk),
    .reset     (reset),
    .push      (s0_valid),
    .din       ('{addr: s0_addr, data: s0_data}),
    .pop       (gnt == GNT_S0),
    .head      (s0_head),
    .empty     (s0_empty),
    .full      (s0_full),
    .ent_valid (s0_ev),
    .ent_addr  (s0_ea)
  );

  rf_wr_fifo #(.DEPTH(DEPTH)) u_fifo_s1 (
    .clk       (clk),
    .reset     (reset),
    .push      (s1_valid),
    .din       ('{addr: s1_addr, data: s1_data}),
    .pop       (gnt == GNT_S1),
    .head      (s1_head),
    .empty     (s1_empty),
    .full      (s1_full),
    .ent_valid (s1_ev),
    .ent_addr  (s1_ea)
  );

  assign s0_ready = !s0_full;
  assign s1_ready = !s1_full;

`ifdef RFARB_RR_EN
  rf_gnt_e rr_last;

  always_comb begin
    gnt = GNT_NONE;
    if (reset)                     gnt = GNT_NONE;
    else if (!s0_empty && !s1_empty) gnt = (rr_last == GNT_S1) ? GNT_S0 : GNT_S1;
    else if (!s1_empty)            gnt = GNT_S1;
    else if (!s0_empty)            gnt = GNT_S0;
  end

  always_ff @(posedge clk) begin
    if (reset)                 rr_last <= GNT_S1;
    else if (gnt != GNT_NONE)  rr_last <= gnt;
  end
`else
  localparam int BW = $clog2(MAX_BURST + 1);
  logic [BW-1:0] burst_cnt;

  // loads win unless s0 has already waited out MAX_BURST load grants
  always_comb begin
    gnt = GNT_NONE;
    if (reset)                       gnt = GNT_NONE;
    else if (!s0_empty && !s1_empty) gnt = (burst_cnt == BW'(MAX_BURST)) ? GNT_S0 : GNT_S1;
    else if (!s1_empty)              gnt = GNT_S1;
    else if (!s0_empty)              gnt = GNT_S0;
  end

  always_ff @(posedge clk) begin
    if (reset)
      burst_cnt <= '0;
    else if (s0_empty || gnt == GNT_S0)
      burst_cnt <= '0;
    else if (gnt == GNT_S1 && burst_cnt != BW'(MAX_BURST))
      burst_cnt <= burst_cnt + BW'(1);
  end
`endif

  always_comb begin
    RegWrite = 1'b0;
    a3       = '0;
    wd3      = '0;
    unique case (gnt)
      GNT_S0: begin
        RegWrite = 1'b1;
        a3       = s0_head.addr;
        wd3      = s0_head.data;
      end
      GNT_S1: begin
        RegWrite = 1'b1;
        a3       = s1_head.addr;
        wd3      = s1_head.data;
      end
      default: ;
    endcase
  end

  // the head being written this cycle still counts as pending
  always_comb begin
    q_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (s0_ev[i] && s0_ea[i] == q_addr) q_pending = 1'b1;
      if (s1_ev[i] && s1_ea[i] == q_addr) q_pending = 1'b1;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_rf_write_arbiter;

  localparam int DEPTH     = 2;
  localparam int MAX_BURST = 4;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  logic        clk;
  logic        reset;
  logic        s0_valid, s1_valid;
  logic        s0_ready, s1_ready;
  logic [4:0]  s0_addr, s1_addr, q_addr, a3;
  logic [31:0] s0_data, s1_data, wd3;
  logic        RegWrite, q_pending;

  int checks = 0;
  int errors = 0;

  ent_t m0[$];
  ent_t m1[$];
  int   burst = 0;
  int   rr = 2;
  bit   model_ok = 0;
  bit   acc0 = 0, acc1 = 0;
  int   wlog[$];

  rf_write_arbiter #(.DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
    .clk       (clk),
    .reset     (reset),
    .s0_valid  (s0_valid),
    .s0_ready  (s0_ready),
    .s0_addr   (s0_addr),
    .s0_data   (s0_data),
    .s1_valid  (s1_valid),
    .s1_ready  (s1_ready),
    .s1_addr   (s1_addr),
    .s1_data   (s1_data),
    .RegWrite  (RegWrite),
    .a3        (a3),
    .wd3       (wd3),
    .q_addr    (q_addr),
    .q_pending (q_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // 0 = nothing, 1 = s0, 2 = s1
  function automatic int model_grant();
    bit n0, n1;
    n0 = (m0.size() > 0);
    n1 = (m1.size() > 0);
    if (reset) return 0;
    if (n0 && n1) begin
`ifdef RFARB_RR_EN
      return (rr == 2) ? 1 : 2;
`else
      return (burst >= MAX_BURST) ? 1 : 2;
`endif
    end
    if (n1) return 2;
    if (n0) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    int g;
    acc0 = 0;
    acc1 = 0;
    if (reset) begin
      m0.delete();
      m1.delete();
      burst    = 0;
      rr       = 2;
      model_ok = 1;
    end else if (model_ok) begin
      g    = model_grant();
      acc0 = s0_valid && (m0.size() < DEPTH);
      acc1 = s1_valid && (m1.size() < DEPTH);
      if (m0.size() == 0 || g == 1) burst = 0;
      else if (g == 2 && burst < MAX_BURST) burst++;
      if (g == 1) void'(m0.pop_front());
      if (g == 2) void'(m1.pop_front());
      if (acc0) m0.push_back('{s0_addr, s0_data});
      if (acc1) m1.push_back('{s1_addr, s1_data});
      if (g != 0) rr = g;
    end
  end

  always @(negedge clk) begin
    int          g;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic        ep;
    if (model_ok) begin
      g  = model_grant();
      ea = (g == 1) ? m0[0].addr : (g == 2) ? m1[0].addr : 5'd0;
      ed = (g == 1) ? m0[0].data : (g == 2) ? m1[0].data : 32'd0;
      ep = 1'b0;
      foreach (m0[i]) if (m0[i].addr == q_addr) ep = 1'b1;
      foreach (m1[i]) if (m1[i].addr == q_addr) ep = 1'b1;
      checkOutput("RegWrite", 32'(RegWrite), 32'(g != 0));
      checkOutput("a3", 32'(a3), 32'(ea));
      checkOutput("wd3", wd3, ed);
      checkOutput("s0_ready", 32'(s0_ready), 32'(m0.size() < DEPTH));
      checkOutput("s1_ready", 32'(s1_ready), 32'(m1.size() < DEPTH));
      checkOutput("q_pending", 32'(q_pending), 32'(ep));
      if (RegWrite === 1'b1) wlog.push_back(int'(a3));
    end
  end

  task automatic setInputs(input logic rst, input logic v0, input logic [4:0] ad0, input logic [31:0] d0,
                           input logic v1, input logic [4:0] ad1, input logic [31:0] d1, input logic [4:0] q);
    reset    = rst;
    s0_valid = v0;
    s0_addr  = ad0;
    s0_data  = d0;
    s1_valid = v1;
    s1_addr  = ad1;
    s1_data  = d1;
    q_addr   = q;
  endtask

  task automatic applyStimulus(input logic rst, input logic v0, input logic [4:0] ad0, input logic [31:0] d0,
                               input logic v1, input logic [4:0] ad1, input logic [31:0] d1, input logic [4:0] q);
    @(posedge clk);
    #1;
    setInputs(rst, v0, ad0, d0, v1, ad1, d1, q);
  endtask

  task automatic idle(input int n, input logic [4:0] q);
    repeat (n) applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, q);
  endtask

  task automatic pulseReset();
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
  endtask

  task automatic checkLog(input string name, input int exp[$]);
    checkOutput({name, "_len"}, 32'(wlog.size()), 32'(exp.size()));
    foreach (exp[i]) begin
      if (i < wlog.size()) checkOutput($sformatf("%s_w%0d", name, i), 32'(wlog[i]), 32'(exp[i]));
    end
  endtask

  initial begin
    int exp_log[$];
    int k0, k1;
    setInputs(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0);
    pulseReset();

    // scenario 1: single ALU write and its hazard window
    applyStimulus(1'b0, 1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0, 5'd3);
    @(negedge clk);
    checkOutput("t1_reset_s0_ready", 32'(s0_ready), 32'd1);
    checkOutput("t1_reset_s1_ready", 32'(s1_ready), 32'd1);
    checkOutput("t1_idle_RegWrite", 32'(RegWrite), 32'd0);
    idle(1, 5'd3);
    @(negedge clk);
    checkOutput("t1_RegWrite", 32'(RegWrite), 32'd1);
    checkOutput("t1_a3", 32'(a3), 32'd3);
    checkOutput("t1_wd3", wd3, 32'h11);
    checkOutput("t1_q_pending_c1", 32'(q_pending), 32'd1);
    idle(1, 5'd3);
    @(negedge clk);
    checkOutput("t1_q_pending_c2", 32'(q_pending), 32'd0);
    checkOutput("t1_RegWrite_c2", 32'(RegWrite), 32'd0);

    // scenario 2: simultaneous pushes
    pulseReset();
    applyStimulus(1'b0, 1'b1, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB, 5'd0);
    wlog.delete();
    idle(3, 5'd0);
`ifdef RFARB_RR_EN
    exp_log = '{1, 2};
`else
    exp_log = '{2, 1};
`endif
    checkLog("t2", exp_log);

    // scenario 3: load stream against one waiting ALU write
    pulseReset();
    applyStimulus(1'b0, 1'b1, 5'd5, 32'h50, 1'b1, 5'd10, 32'h100, 5'd0);
    wlog.delete();
    for (int i = 11; i <= 15; i++)
      applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'(256 + i), 5'd0);
    idle(4, 5'd0);
`ifdef RFARB_RR_EN
    exp_log = '{5, 10, 11, 13, 14, 15};
`else
    exp_log = '{10, 11, 12, 13, 5, 14, 15};
`endif
    checkLog("t3", exp_log);

    // scenario 4: fill s0 behind load traffic, then wrap the pointers
    pulseReset();
    applyStimulus(1'b0, 1'b1, 5'd1, 32'h100, 1'b1, 5'd20, 32'h2000, 5'd1);
    applyStimulus(1'b0, 1'b1, 5'd2, 32'h200, 1'b1, 5'd21, 32'h2001, 5'd2);
    applyStimulus(1'b0, 1'b1, 5'd3, 32'h300, 1'b1, 5'd22, 32'h2002, 5'd3);
`ifndef RFARB_RR_EN
    @(negedge clk);
    checkOutput("t4_s0_full_ready", 32'(s0_ready), 32'd0);
`endif
    idle(1, 5'd0);
    k0 = 0;
    k1 = 0;
    for (int c = 0; c < 60 && (k0 < 10 || k1 < 10); c++) begin
      @(posedge clk);
      #1;
      if (acc0 && s0_valid) k0++;
      if (acc1 && s1_valid) k1++;
      setInputs(1'b0, k0 < 10, 5'(k0 % 8 + 1), 32'h4000 + 32'(k0),
                k1 < 10, 5'(k1 % 8 + 16), 32'h5000 + 32'(k1), 5'(k0 % 8 + 1));
    end
    idle(6, 5'd0);

    // scenario 5: reset with writes buffered
    pulseReset();
    applyStimulus(1'b0, 1'b1, 5'd7, 32'h70, 1'b1, 5'd8, 32'h80, 5'd7);
    applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7);
    @(negedge clk);
    checkOutput("t5_reset_RegWrite", 32'(RegWrite), 32'd0);
    idle(1, 5'd7);
    @(negedge clk);
    checkOutput("t5_RegWrite", 32'(RegWrite), 32'd0);
    checkOutput("t5_q_pending", 32'(q_pending), 32'd0);
    checkOutput("t5_s0_ready", 32'(s0_ready), 32'd1);
    checkOutput("t5_s1_ready", 32'(s1_ready), 32'd1);

    // scenario 6: r15 write passes through unchanged
    applyStimulus(1'b0, 1'b1, 5'd15, 32'hDEAD, 1'b0, 5'd0, 32'd0, 5'd15);
    idle(1, 5'd15);
    @(negedge clk);
    checkOutput("t6_RegWrite", 32'(RegWrite), 32'd1);
    checkOutput("t6_a3", 32'(a3), 32'd15);
    checkOutput("t6_wd3", wd3, 32'hDEAD);
    idle(2, 5'd0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(99) == 0, 1'($urandom), 5'($urandom_range(7)), $urandom,
                    1'($urandom), 5'($urandom_range(7)), $urandom, 5'($urandom_range(7)));
    end
    idle(4, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
